// File: rtl/imem_access_arbiter.sv
// Two-requester round-robin arbiter for the single IMEM port: one transaction
// in flight, read latency sequencing, out-of-range rejection without a memory access.
//
// state   | meaning
// IDLE    | no transaction; arbitrate between pending requests
// WRITE   | one-cycle write strobe on the IMEM port
// RD_WAIT | address on the IMEM port, counting down read latency
// DONE    | ack pulse to the grantee; requests ignored
module imem_access_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_wre,
  output logic [DATA_W-1:0] imem_wr_data,
  input  logic [DATA_W-1:0] imem_rd_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WRITE, RD_WAIT, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [2:0]      LAT       = 3'(RD_LAT);

  state_t            state, state_n;
  logic              last, last_n;
  logic              gnt, gnt_n;
  logic [2:0]        cnt, cnt_n;
  logic [ADDR_W-1:0] imem_addr_n;
  logic              imem_wre_n;
  logic [DATA_W-1:0] imem_wr_data_n;
  logic [1:0]        ack_n, err_n;
  logic [DATA_W-1:0] rdata0_n, rdata1_n;
  logic              sel, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    state_n        = state;
    last_n         = last;
    gnt_n          = gnt;
    cnt_n          = cnt;
    imem_addr_n    = imem_addr;
    imem_wre_n     = 1'b0;
    imem_wr_data_n = imem_wr_data;
    ack_n          = 2'b00;
    err_n          = 2'b00;
    rdata0_n       = m0_rdata;
    rdata1_n       = m1_rdata;
    // on a tie the master that was not granted last wins
    sel       = (m0_req && m1_req) ? ~last : m1_req;
    sel_we    = sel ? m1_we    : m0_we;
    sel_addr  = sel ? m1_addr  : m0_addr;
    sel_wdata = sel ? m1_wdata : m0_wdata;

    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          gnt_n  = sel;
          last_n = sel;
          if ({1'b0, sel_addr} >= DEPTH_EXT) begin
            state_n    = DONE;
            ack_n[sel] = 1'b1;
            err_n[sel] = 1'b1;
          end else begin
            imem_addr_n = sel_addr;
            if (sel_we) begin
              state_n        = WRITE;
              imem_wre_n     = 1'b1;
              imem_wr_data_n = sel_wdata;
            end else begin
              state_n = RD_WAIT;
              cnt_n   = LAT;
            end
          end
        end
      end
      WRITE: begin
        state_n    = DONE;
        ack_n[gnt] = 1'b1;
      end
      RD_WAIT: begin
        if (cnt == 3'd0) begin
          state_n    = DONE;
          ack_n[gnt] = 1'b1;
          if (gnt) rdata1_n = imem_rd_data;
          else     rdata0_n = imem_rd_data;
        end else begin
          cnt_n = cnt - 3'd1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last         <= 1'b1;
      gnt          <= 1'b0;
      cnt          <= 3'd0;
      imem_addr    <= '0;
      imem_wre     <= 1'b0;
      imem_wr_data <= '0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      m0_err       <= 1'b0;
      m1_err       <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      last         <= last_n;
      gnt          <= gnt_n;
      cnt          <= cnt_n;
      imem_addr    <= imem_addr_n;
      imem_wre     <= imem_wre_n;
      imem_wr_data <= imem_wr_data_n;
      m0_ack       <= ack_n[0];
      m1_ack       <= ack_n[1];
      m0_err       <= err_n[0];
      m1_err       <= err_n[1];
      m0_rdata     <= rdata0_n;
      m1_rdata     <= rdata1_n;
      busy         <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Bench for imem_access_arbiter: directed scenarios, then random traffic from both
// masters scored against a transaction-level model; extra RD_LAT=0/3 instances.
module tb_imem_access_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int RD_LAT = 1;
  localparam logic [31:0] D_PAIR = 32'h1111_2222;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int n_done  = 0;
  int tick    = 0;
  always @(posedge clk) tick <= tick + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [1:0]        req, we, ack, err;
  logic [ADDR_W-1:0] addr [2];
  logic [DATA_W-1:0] wdata [2];
  logic [DATA_W-1:0] rdata [2];
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_wre, busy;
  logic [DATA_W-1:0] imem_wr_data, imem_rd_data;

  imem_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_ack(ack[0]), .m0_err(err[0]), .m0_rdata(rdata[0]),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_ack(ack[1]), .m1_err(err[1]), .m1_rdata(rdata[1]),
    .imem_addr(imem_addr), .imem_wre(imem_wre), .imem_wr_data(imem_wr_data),
    .imem_rd_data(imem_rd_data), .busy(busy)
  );

  // IMEM model: one-cycle read latency from the address
  logic [31:0] mem [DEPTH];
  logic [31:0] a_d1;
  always @(posedge clk) begin
    if (preload) for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA500_0000 | i;
    else if (imem_wre) mem[imem_addr[5:0]] <= imem_wr_data;
    a_d1 <= imem_addr;
  end
  assign imem_rd_data = mem[a_d1[5:0]];

  // single-master transaction; starts and returns just after a rising edge
  task automatic txn(input int m, input bit w, input logic [31:0] a, input logic [31:0] d,
                     output int cyc, output int wre_n, output int wre_at, output int oth,
                     output bit e, output logic [31:0] rd);
    bit got = 0;
    req[m] = 1'b1; we[m] = w; addr[m] = a; wdata[m] = d;
    cyc = 0; wre_n = 0; wre_at = -1; oth = 0; e = 0; rd = '0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      if (imem_wre) begin wre_n++; wre_at = cyc; end
      if (ack[1-m]) oth++;
      if (ack[m]) begin got = 1; e = err[m]; rd = rdata[m]; end
      else cyc++;
    end
    check("txn_ack_seen", got, 1);
    @(posedge clk); #1;
    req[m] = 1'b0;
  endtask

  // both masters request together and hold for reps transactions each
  task automatic pair(input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                      input bit w1, input logic [31:0] a1, input logic [31:0] d1, input int reps);
    int n[2] = '{0, 0};
    int k = 0;
    int g = 0;
    logic [1:0] prev = 2'b00;
    we[0] = w0; addr[0] = a0; wdata[0] = d0;
    we[1] = w1; addr[1] = a1; wdata[1] = d1;
    req = 2'b11;
    while (k < 2*reps && g < 100) begin
      @(negedge clk); g++;
      for (int m = 0; m < 2; m++) if (ack[m]) begin
        check("pair_pulse", prev[m], 0);
        check("pair_order", m, k % 2);
        k++; n[m]++;
      end
      prev = ack;
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) if (n[m] == reps) req[m] = 1'b0;
    end
    check("pair_count", k, 2*reps);
    @(negedge clk);
    check("pair_tail", ack, 2'b00);
    @(posedge clk); #1;
  endtask

  // random phase scoreboard
  bit          rnd_on = 0;
  bit          pend [2];
  bit          tx_we [2];
  logic [31:0] tx_addr [2];
  logic [31:0] tx_wd [2];
  int          t_raise [2];
  logic [31:0] ref_mem [DEPTH];
  int          wre_since = 0;
  int          exp_next = -1;

  always @(negedge clk) begin : mon
    bit e;
    int minl, lat;
    if (rnd_on) begin
      if (imem_wre) wre_since++;
      for (int m = 0; m < 2; m++) if (ack[m]) begin
        check("rnd_ack_owner", pend[m], 1);
        if (pend[m]) begin
          e    = (tx_addr[m] >= DEPTH);
          minl = e ? 1 : (tx_we[m] ? 2 : 2 + RD_LAT);
          lat  = tick - t_raise[m];
          check("rnd_err", err[m], e);
          check("rnd_latency_in_window", (lat >= minl && lat <= minl + 3 + RD_LAT), 1);
          if (!e && !tx_we[m]) check("rnd_rdata", rdata[m], ref_mem[tx_addr[m][5:0]]);
          if (!e && tx_we[m]) ref_mem[tx_addr[m][5:0]] = tx_wd[m];
          check("rnd_wre_count", wre_since, (!e && tx_we[m]) ? 1 : 0);
          if (exp_next >= 0) check("rnd_round_robin", m, exp_next);
          exp_next = pend[1-m] ? 1 - m : -1;
          wre_since = 0;
          pend[m] = 0;
        end
      end
    end
  end

  task automatic drive(input int m, input int ntx);
    int gap, g;
    for (int i = 0; i < ntx; i++) begin
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        req[m] = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      we[m] = 1'($urandom_range(0, 1)); addr[m] = $urandom_range(0, 79); wdata[m] = $urandom;
      tx_we[m] = we[m]; tx_addr[m] = addr[m]; tx_wd[m] = wdata[m];
      t_raise[m] = tick; pend[m] = 1; req[m] = 1'b1;
      g = 0;
      while (pend[m] && g < 100) begin @(posedge clk); g++; end
      #1;
      if (pend[m]) begin check("rnd_ack_timeout", pend[m], 0); pend[m] = 0; end
    end
    req[m] = 1'b0;
  endtask

  initial begin : main
    int cyc, wre_n, wre_at, oth;
    bit e;
    logic [31:0] rd;
    req = 2'b00; we = 2'b00;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_wre", imem_wre, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wr_data", imem_wr_data, 0);
    check("rst_rdata0", rdata[0], 0);
    check("rst_rdata1", rdata[1], 0);
    @(posedge clk); #1;
    rst = 1'b0; preload = 1'b0;

    txn(0, 1, 5, 32'hDEAD_BEEF, cyc, wre_n, wre_at, oth, e, rd);
    check("wr_ack_cycle", cyc, 2);
    check("wr_wre_count", wre_n, 1);
    check("wr_wre_cycle", wre_at, 1);
    check("wr_err", e, 0);
    check("wr_other_ack", oth, 0);

    txn(1, 0, 5, 0, cyc, wre_n, wre_at, oth, e, rd);
    check("rd_ack_cycle", cyc, 2 + RD_LAT);
    check("rd_data", rd, 32'hDEAD_BEEF);
    check("rd_wre_count", wre_n, 0);
    check("rd_err", e, 0);

    pair(1, 10, D_PAIR, 0, 5, 0, 2);
    check("pair_m1_rdata", rdata[1], 32'hDEAD_BEEF);

    txn(1, 0, 64, 0, cyc, wre_n, wre_at, oth, e, rd);
    check("oor_ack_cycle", cyc, 1);
    check("oor_err", e, 1);
    check("oor_wre_count", wre_n, 0);
    check("oor_other_ack", oth, 0);
    check("oor_addr_held", imem_addr, 5);
    check("oor_wr_data_held", imem_wr_data, D_PAIR);

    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 7;
    @(posedge clk); #1;
    rst = 1'b1; req[0] = 1'b0;
    @(negedge clk);
    check("mid_busy_before_rst", busy, 1);
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ack", ack, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_wre", imem_wre, 0);
    check("mid_rst_rdata1", rdata[1], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    pair(0, 5, 0, 0, 5, 0, 1);
    check("post_rst_rdata0", rdata[0], 32'hDEAD_BEEF);
    check("post_rst_rdata1", rdata[1], 32'hDEAD_BEEF);

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'hA500_0000 | i;
    ref_mem[5]  = 32'hDEAD_BEEF;
    ref_mem[10] = D_PAIR;
    pend[0] = 0; pend[1] = 0;
    rnd_on = 1;
    fork
      drive(0, 60);
      drive(1, 60);
    join
    repeat (2) @(posedge clk);
    rnd_on = 0;

    for (int i = 0; i < 1000 && n_done < 2; i++) @(posedge clk);
    check("lat_builds_done", n_done, 2);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // RD_LAT=0 and RD_LAT=3 builds: write then read word 0
  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int L = (g == 0) ? 0 : 3;
    logic              xrst;
    logic [1:0]        xreq, xwe, xack, xerr;
    logic [31:0]       xaddr [2];
    logic [31:0]       xwdata [2];
    logic [31:0]       xrdata [2];
    logic [31:0]       xi_addr, xi_wd, xi_rd;
    logic              xi_wre, xbusy;
    logic [31:0]       xmem [DEPTH];
    logic [31:0]       ap [3];

    imem_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(L)) dut_x (
      .clk(clk), .rst(xrst),
      .m0_req(xreq[0]), .m0_we(xwe[0]), .m0_addr(xaddr[0]), .m0_wdata(xwdata[0]),
      .m0_ack(xack[0]), .m0_err(xerr[0]), .m0_rdata(xrdata[0]),
      .m1_req(xreq[1]), .m1_we(xwe[1]), .m1_addr(xaddr[1]), .m1_wdata(xwdata[1]),
      .m1_ack(xack[1]), .m1_err(xerr[1]), .m1_rdata(xrdata[1]),
      .imem_addr(xi_addr), .imem_wre(xi_wre), .imem_wr_data(xi_wd),
      .imem_rd_data(xi_rd), .busy(xbusy)
    );

    always @(posedge clk) begin
      if (preload) for (int i = 0; i < DEPTH; i++) xmem[i] <= 32'h5A00_0000 | i;
      else if (xi_wre) xmem[xi_addr[5:0]] <= xi_wd;
      ap[0] <= xi_addr;
      ap[1] <= ap[0];
      ap[2] <= ap[1];
    end
    if (L == 0) begin : g_comb
      assign xi_rd = xmem[xi_addr[5:0]];
    end else begin : g_pipe
      assign xi_rd = xmem[ap[L-1][5:0]];
    end

    initial begin
      int  cyc;
      bit  got;
      xrst = 1'b1; xreq = 2'b00; xwe = 2'b00;
      xaddr[0] = '0; xaddr[1] = '0; xwdata[0] = '0; xwdata[1] = '0;
      repeat (3) @(posedge clk);
      #1 xrst = 1'b0;
      @(posedge clk); #1;
      xreq[0] = 1'b1; xwe[0] = 1'b1; xaddr[0] = 0; xwdata[0] = 32'hC0DE_0000 | L;
      cyc = 0; got = 0;
      while (!got && cyc < 30) begin @(negedge clk); if (xack[0]) got = 1; else cyc++; end
      check("lat_wr_ack_cycle", cyc, 2);
      @(posedge clk); #1;
      xreq[0] = 1'b0;
      @(posedge clk); #1;
      xreq[0] = 1'b1; xwe[0] = 1'b0;
      cyc = 0; got = 0;
      while (!got && cyc < 30) begin @(negedge clk); if (xack[0]) got = 1; else cyc++; end
      check("lat_rd_ack_cycle", cyc, 2 + L);
      check("lat_rd_data", xrdata[0], 32'hC0DE_0000 | L);
      check("lat_m1_ack", xack[1], 0);
      @(posedge clk); #1;
      xreq[0] = 1'b0;
      @(negedge clk);
      check("lat_busy_idle", xbusy, 0);
      check("lat_m1_rdata", xrdata[1] | {31'b0, xerr[1]}, 0);
      n_done++;
    end
  end

endmodule

// File: doc/imem_access_arbiter.md
Name: imem_access_arbiter

Overview:
- Shares the single IMEM port (address, write enable, write data, read data) between two requesters.
- Requester 0 is the program loader, normally driven from the VIO. Requester 1 is the instruction fetch path.
- Round-robin arbitration, one transaction in flight at a time.
- Sequences IMEM read latency and rejects out-of-range addresses without touching the memory.

Parameters:
- ADDR_W, 32, width of the word address.
- DATA_W, 32, width of the instruction word.
- DEPTH, 64, number of IMEM words; valid addresses are 0..DEPTH-1.
- RD_LAT, 1, cycles from imem_addr driven to imem_rd_data valid; legal range 0..7.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req, m1_req  in  1  request; held stable until ack.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_addr, m1_addr  in  ADDR_W  word address.
- m0_wdata, m1_wdata  in  DATA_W  write data.
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- m0_err, m1_err  out  1  valid with ack; address out of range.
- m0_rdata, m1_rdata  out  DATA_W  read data; valid with ack and held until that master's next read ack.
- imem_addr  out  ADDR_W  to IMEM i_addr.
- imem_wre  out  1  to IMEM wre.
- imem_wr_data  out  DATA_W  to IMEM wr_data.
- imem_rd_data  in  DATA_W  from IMEM i_data.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- One clock and a synchronous, active-high reset: clk and rst. All outputs are registered.
- Reset values:
  - all outputs 0;
  - state IDLE;
  - round-robin pointer last = 1, so m0 wins the first tie.
- FSM states: IDLE, WRITE, RD_WAIT, DONE.
- IDLE:
  - Only one master requesting: that master is granted.
  - Both requesting: the master not equal to last is granted; last updates to the grantee.
  - On grant, latch we, addr and wdata.
  - addr >= DEPTH: go to DONE with err=1 and no IMEM access.
  - Otherwise go to WRITE if we=1, else go to RD_WAIT.
- WRITE:
  - imem_addr = addr, imem_wre = 1, imem_wr_data = wdata for exactly one cycle.
  - Then go to DONE.
- RD_WAIT:
  - imem_addr = addr, imem_wre = 0.
  - Wait counter loads RD_LAT.
  - imem_rd_data is captured in the cycle the counter reaches 0; then go to DONE.
- DONE:
  - Grantee's ack = 1 for one cycle, with err, and with rdata if it was a read.
  - Both masters' requests are ignored in this cycle.
  - Next state is IDLE.
- Latency, with req first sampled in cycle 0 and the arbiter idle:
  - write: ack in cycle 2;
  - read: ack in cycle 2+RD_LAT;
  - out-of-range: ack+err in cycle 1.
- Back-to-back: a master keeping req high in the cycle after its ack starts a new transaction. If the other master is waiting, round-robin grants the other master first.
- imem_wre is 1 only in WRITE. imem_addr and imem_wr_data hold their last values outside an access.
- Requests arriving while busy wait; they are never dropped.
- A master deasserting req before ack: undefined. The arbiter still completes the transaction and pulses ack.
- Reset mid-operation:
  - next edge forces IDLE, imem_wre = 0, all acks and errs 0;
  - rdata registers cleared;
  - the pending transaction is lost with no ack.
- Address compare is unsigned on the full ADDR_W.

Test Plan:
- Reset, then m0 writes addr 5, data 0xDEADBEEF -> imem_wre high in cycle 1 only; m0_ack in cycle 2; err=0; m1_ack never pulses.
- m1 reads addr 5 with RD_LAT=1 and the IMEM model returning the stored word -> m1_ack in cycle 3; m1_rdata=0xDEADBEEF; imem_wre stays 0.
- m0 and m1 request in the same cycle, repeated 4 times back-to-back -> grants alternate m0, m1, m0, m1; every ack is a single-cycle pulse.
- m1 reads addr 64 with DEPTH=64 -> m1_ack and m1_err high in cycle 1; imem_wre and imem_addr unchanged.
- rst asserted during RD_WAIT of a pending read -> next cycle busy=0, no ack; a subsequent m1 read completes normally with m0 winning the first tie.
- RD_LAT=0 and RD_LAT=3 builds, read addr 0 -> ack in cycle 2 and cycle 5 respectively, with correct data.
